ycbcr_to_rgb: RTL



---
 rtl/ycbcr_to_rgb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ycbcr_to_rgb.sv
// Pipelined BT.601 studio-swing YCbCr -> RGB888 converter with matched sync/data_en delay.
// Optional macro YCBCR422_IN_EN: 4:2:2 input (shared chroma byte on i_cb_8b), latency 5 instead of 4.
module ycbcr_to_rgb #(
    parameter int COEF_Y    = 298,
    parameter int COEF_CR_R = 409,
    parameter int COEF_CB_G = 100,
    parameter int COEF_CR_G = 208,
    parameter int COEF_CB_B = 516,
    parameter int Y_OFFSET  = 16,
    parameter int C_OFFSET  = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_y_8b,
    input  logic [7:0] i_cb_8b,
    input  logic [7:0] i_cr_8b,
    input  logic       i_h_sync,
    input  logic       i_v_sync,
    input  logic       i_data_en,
    output logic [7:0] o_r_8b,
    output logic [7:0] o_g_8b,
    output logic [7:0] o_b_8b,
    output logic       o_h_sync,
    output logic       o_v_sync,
    output logic       o_data_en
);
    localparam int CTL_DEPTH = 4;
    localparam logic signed [19:0] K_Y    = 20'(COEF_Y);
    localparam logic signed [19:0] K_CR_R = 20'(COEF_CR_R);
    localparam logic signed [19:0] K_CB_G = 20'(COEF_CB_G);
    localparam logic signed [19:0] K_CR_G = 20'(COEF_CR_G);
    localparam logic signed [19:0] K_CB_B = 20'(COEF_CB_B);
    localparam logic signed [8:0]  K_YOFS = 9'(Y_OFFSET);
    localparam logic signed [8:0]  K_COFS = 9'(C_OFFSET);

    logic [7:0] w_y, w_cb, w_cr;
    logic       w_hs, w_vs, w_de;

`ifdef YCBCR422_IN_EN
    localparam logic [7:0] C_ZERO8 = 8'(C_OFFSET);

    logic       r_phase, r_de_d, w_phase;
    logic [7:0] r_pre_y, r_cb_lat, r_cr_hold, w_cr_pair;
    logic       r_pre_phase, r_pre_hs, r_pre_vs, r_pre_de;

    // First pixel of each data_en burst is always the even (Cb-carrying) one.
    assign w_phase   = (i_data_en && !r_de_d) ? 1'b0 : r_phase;
    // Partner Cr for a delayed even pixel; a trailing even pixel gets neutral chroma.
    assign w_cr_pair = (i_data_en && w_phase) ? i_cb_8b : C_ZERO8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 1'b0;
            r_de_d      <= 1'b0;
            r_cb_lat    <= '0;
            r_cr_hold   <= '0;
            r_pre_y     <= '0;
            r_pre_phase <= 1'b0;
            r_pre_hs    <= 1'b0;
            r_pre_vs    <= 1'b0;
            r_pre_de    <= 1'b0;
        end else begin
            r_de_d <= i_data_en;
            if (i_data_en) begin
                r_phase <= ~w_phase;
            end
            if (i_data_en && !w_phase) begin
                r_cb_lat <= i_cb_8b;
            end
            if (!r_pre_phase) begin
                r_cr_hold <= w_cr_pair;
            end
            r_pre_y     <= i_y_8b;
            r_pre_phase <= w_phase;
            r_pre_hs    <= i_h_sync;
            r_pre_vs    <= i_v_sync;
            r_pre_de    <= i_data_en;
        end
    end

    assign w_y  = r_pre_y;
    assign w_cb = r_cb_lat;
    assign w_cr = r_pre_phase ? r_cr_hold : w_cr_pair;
    assign w_hs = r_pre_hs;
    assign w_vs = r_pre_vs;
    assign w_de = r_pre_de;
`else
    assign w_y  = i_y_8b;
    assign w_cb = i_cb_8b;
    assign w_cr = i_cr_8b;
    assign w_hs = i_h_sync;
    assign w_vs = i_v_sync;
    assign w_de = i_data_en;
`endif

    logic signed [8:0]  r_yd, r_cbd, r_crd;
    logic signed [19:0] w_yd_x, w_cbd_x, w_crd_x;
    logic signed [19:0] r_p_y, r_p_crr, r_p_cbg, r_p_crg, r_p_cbb;
    logic signed [19:0] r_s [3];
    logic signed [11:0] w_hi [3];
    logic [7:0]         w_clip [3];
    logic [7:0]         r_rgb [3];
    logic [2:0]         r_ctl [CTL_DEPTH];

    assign w_yd_x  = {{11{r_yd[8]}},  r_yd};
    assign w_cbd_x = {{11{r_cbd[8]}}, r_cbd};
    assign w_crd_x = {{11{r_crd[8]}}, r_crd};

    // Round half-up, then keep the integer part; the top bit flags negatives.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_clip
            assign w_hi[gi]   = 12'((r_s[gi] + 20'sd128) >>> 8);
            assign w_clip[gi] = w_hi[gi][11]       ? 8'd0   :
                                (|w_hi[gi][10:8])  ? 8'd255 : w_hi[gi][7:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yd    <= '0;
            r_cbd   <= '0;
            r_crd   <= '0;
            r_p_y   <= '0;
            r_p_crr <= '0;
            r_p_cbg <= '0;
            r_p_crg <= '0;
            r_p_cbb <= '0;
            for (int i = 0; i < 3; i++) begin
                r_s[i]   <= '0;
                r_rgb[i] <= '0;
            end
            for (int i = 0; i < CTL_DEPTH; i++) begin
                r_ctl[i] <= '0;
            end
        end else begin
            r_yd    <= $signed({1'b0, w_y})  - K_YOFS;
            r_cbd   <= $signed({1'b0, w_cb}) - K_COFS;
            r_crd   <= $signed({1'b0, w_cr}) - K_COFS;
            r_p_y   <= K_Y    * w_yd_x;
            r_p_crr <= K_CR_R * w_crd_x;
            r_p_cbg <= K_CB_G * w_cbd_x;
            r_p_crg <= K_CR_G * w_crd_x;
            r_p_cbb <= K_CB_B * w_cbd_x;
            r_s[0]  <= r_p_y + r_p_crr;
            r_s[1]  <= r_p_y - r_p_cbg - r_p_crg;
            r_s[2]  <= r_p_y + r_p_cbb;
            for (int i = 0; i < 3; i++) begin
                r_rgb[i] <= w_clip[i];
            end
            r_ctl[0] <= {w_vs, w_hs, w_de};
            for (int i = 1; i < CTL_DEPTH; i++) begin
                r_ctl[i] <= r_ctl[i-1];
            end
        end
    end

    assign o_r_8b    = r_rgb[0];
    assign o_g_8b    = r_rgb[1];
    assign o_b_8b    = r_rgb[2];
    assign o_data_en = r_ctl[CTL_DEPTH-1][0];
    assign o_h_sync  = r_ctl[CTL_DEPTH-1][1];
    assign o_v_sync  = r_ctl[CTL_DEPTH-1][2];
endmodule
